// File: rtl/riscv_core_mc.sv
// riscv_core_mc: multi-cycle RV32I core with req/ack instruction and data buses,
// bus timeout detection, misaligned-fetch trap and retired-instruction counter.
module riscv_core_mc #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned WAIT_TIMEOUT = 0,
  parameter int unsigned COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [31:0]        imem_rdata_i,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [2:0]         dmem_size_o,
  output logic [31:0]        dmem_addr_o,
  output logic [31:0]        dmem_wdata_o,
  input  logic               dmem_ack_i,
  input  logic [31:0]        dmem_rdata_i,
  output logic               bus_err_o,
  output logic               halted_o,
  output logic [COUNT_W-1:0] instret_o
);

  typedef enum logic [1:0] {
    S_FETCH, S_EXEC, S_MEM, S_HALT
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TMO = 32'(WAIT_TIMEOUT);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_OPI   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  state_t state, state_d;

  logic [31:0]        pc, ir;
  logic [31:0]        rf [32];
  logic [31:0]        m_addr, m_wdata;
  logic               m_we;
  logic [2:0]         m_size;
  logic [31:0]        wcnt;
  logic [COUNT_W-1:0] instret;
  logic               bus_err;

  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        is_lui, is_auipc, is_jal, is_jalr;
  logic        is_br, is_ld, is_st, is_opi, is_op;
  logic [31:0] rs1v, rs2v, alu_b, alu_y;
  logic [31:0] ex_wd, ex_pc, ex_addr, pc_p4;
  logic        ex_we, take;

  logic        imem_req, dmem_req, tmo_hit;
  logic        ir_ld, mem_ld, pc_ld, rf_we, retire;
  logic        err_set, wcnt_clr, wcnt_inc;
  logic [31:0] pc_d, rf_wd;

  assign opc   = ir[6:0];
  assign rd    = ir[11:7];
  assign f3    = ir[14:12];
  assign rs1   = ir[19:15];
  assign rs2   = ir[24:20];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'h000};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  assign is_lui   = (opc == OP_LUI);
  assign is_auipc = (opc == OP_AUIPC);
  assign is_jal   = (opc == OP_JAL);
  assign is_jalr  = (opc == OP_JALR);
  assign is_br    = (opc == OP_BR);
  assign is_ld    = (opc == OP_LD);
  assign is_st    = (opc == OP_ST);
  assign is_opi   = (opc == OP_OPI);
  assign is_op    = (opc == OP_OP);

  assign rs1v  = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2v  = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign alu_b = is_op ? rs2v : imm_i;
  assign pc_p4 = pc + 32'd4;
  assign ex_we = is_lui | is_auipc | is_jal
               | is_jalr | is_opi | is_op;
  assign ex_addr = rs1v + (is_st ? imm_s : imm_i);

  assign tmo_hit = (TMO != 32'd0) && (wcnt + 32'd1 == TMO);

  // ALU for register and immediate arithmetic
  always_comb begin
    alu_y = 32'd0;
    unique case (f3)
      3'b000: alu_y = (is_op && ir[30]) ? rs1v - alu_b
                                        : rs1v + alu_b;
      3'b001: alu_y = rs1v << alu_b[4:0];
      3'b010: alu_y = {31'd0, $signed(rs1v) < $signed(alu_b)};
      3'b011: alu_y = {31'd0, rs1v < alu_b};
      3'b100: alu_y = rs1v ^ alu_b;
      3'b101: alu_y = ir[30] ? 32'($signed(rs1v) >>> alu_b[4:0])
                             : rs1v >> alu_b[4:0];
      3'b110: alu_y = rs1v | alu_b;
      3'b111: alu_y = rs1v & alu_b;
      default: alu_y = 32'd0;
    endcase
  end

  // branch condition flag
  always_comb begin
    take = 1'b0;
    case (f3)
      3'b000:  take = (rs1v == rs2v);
      3'b001:  take = (rs1v != rs2v);
      3'b100:  take = ($signed(rs1v) < $signed(rs2v));
      3'b101:  take = ($signed(rs1v) >= $signed(rs2v));
      3'b110:  take = (rs1v < rs2v);
      3'b111:  take = (rs1v >= rs2v);
      default: take = 1'b0;
    endcase
  end

  // EXEC writeback value and next PC
  always_comb begin
    ex_wd = alu_y;
    ex_pc = pc_p4;
    unique case (1'b1)
      is_lui:           ex_wd = imm_u;
      is_auipc:         ex_wd = pc + imm_u;
      is_jal, is_jalr:  ex_wd = pc_p4;
      default:          ex_wd = alu_y;
    endcase
    unique case (1'b1)
      is_jal:         ex_pc = pc + imm_j;
      is_jalr:        ex_pc = (rs1v + imm_i) & ~32'd1;
      is_br && take:  ex_pc = pc + imm_b;
      default:        ex_pc = pc_p4;
    endcase
  end

  // next-state and control strobes
  always_comb begin
    state_d  = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_ld    = 1'b0;
    mem_ld   = 1'b0;
    pc_ld    = 1'b0;
    pc_d     = pc_p4;
    rf_we    = 1'b0;
    rf_wd    = ex_wd;
    retire   = 1'b0;
    err_set  = 1'b0;
    wcnt_clr = 1'b0;
    wcnt_inc = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (pc[1:0] != 2'b00) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end else begin
          imem_req = 1'b1;
          if (imem_ack_i) begin
            ir_ld    = 1'b1;
            wcnt_clr = 1'b1;
            state_d  = S_EXEC;
          end else if (tmo_hit) begin
            err_set = 1'b1;
            state_d = S_HALT;
          end else begin
            wcnt_inc = 1'b1;
          end
        end
      end
      S_EXEC: begin
        wcnt_clr = 1'b1;
        if (is_ld || is_st) begin
          mem_ld  = 1'b1;
          state_d = S_MEM;
        end else begin
          rf_we   = ex_we;
          pc_ld   = 1'b1;
          pc_d    = ex_pc;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack_i) begin
          rf_we    = ~m_we;
          rf_wd    = dmem_rdata_i;
          pc_ld    = 1'b1;
          retire   = 1'b1;
          wcnt_clr = 1'b1;
          state_d  = S_FETCH;
        end else if (tmo_hit) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end else begin
          wcnt_inc = 1'b1;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // state register and architectural/bus-side registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= NOP;
      m_addr  <= 32'd0;
      m_wdata <= 32'd0;
      m_we    <= 1'b0;
      m_size  <= 3'd0;
      wcnt    <= 32'd0;
      instret <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= state_d;
      if (ir_ld) ir <= imem_rdata_i;
      if (pc_ld) pc <= pc_d;
      if (mem_ld) begin
        m_addr  <= ex_addr;
        m_wdata <= rs2v;
        m_we    <= is_st;
        m_size  <= f3;
      end
      if (retire) instret <= instret + COUNT_W'(1);
      if (err_set) bus_err <= 1'b1;
      if (wcnt_clr) wcnt <= 32'd0;
      else if (wcnt_inc) wcnt <= wcnt + 32'd1;
    end
  end

  // register file write port, x0 stays zero
  always_ff @(posedge clk) begin
    if (!rst && rf_we && rd != 5'd0) rf[rd] <= rf_wd;
  end

  assign imem_req_o   = imem_req & ~rst;
  assign imem_addr_o  = pc;
  assign dmem_req_o   = dmem_req & ~rst;
  assign dmem_we_o    = m_we;
  assign dmem_size_o  = m_size;
  assign dmem_addr_o  = m_addr;
  assign dmem_wdata_o = m_wdata;
  assign bus_err_o    = bus_err;
  assign halted_o     = (state == S_HALT);
  assign instret_o    = instret;

endmodule

// File: tb/tb_riscv_core_mc.sv
// tb_riscv_core_mc: directed program vectors plus hand sequences
// for reset, wait states, timeout and jalr on riscv_core_mc.
module tb_riscv_core_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o, imem_ack_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [2:0]  dmem_size_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic        bus_err_o, halted_o;
  logic [31:0] instret_o;

  riscv_core_mc #(
    .RESET_PC(32'h0000_0100),
    .WAIT_TIMEOUT(4),
    .COUNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_size_o(dmem_size_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i),
    .bus_err_o(bus_err_o), .halted_o(halted_o),
    .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int          ilat, dlat, iw, dw;
  bit          spur_i, spur_d, d_unst;
  logic [31:0] d_a0, d_w0, st_addr, st_data;
  logic        d_we0;
  int          n_chk, n_fail;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] i_t(int imm, int rs1, int f3,
                                      int rd, logic [6:0] op);
    logic [31:0] m;
    m = imm;
    return {m[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return i_t(imm, rs1, 0, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] opi(int f3, int rd, int rs1, int imm);
    return i_t(imm, rs1, f3, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] rr(int f7, int f3, int rd,
                                     int rs1, int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] u_t(int rd, int imm, logic [6:0] op);
    logic [31:0] m;
    m = imm;
    return {m[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] sw(int rs2, int rs1, int imm);
    logic [31:0] m;
    m = imm;
    return {m[11:5], 5'(rs2), 5'(rs1), 3'b010, m[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] lw(int rd, int rs1, int imm);
    return i_t(imm, rs1, 2, rd, 7'b0000011);
  endfunction

  function automatic logic [31:0] br(int f3, int rs1, int rs2, int imm);
    logic [31:0] m;
    m = imm;
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3),
            m[4:1], m[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] jal(int rd, int imm);
    logic [31:0] m;
    m = imm;
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic logic [31:0] jalr(int rd, int rs1, int imm);
    return i_t(imm, rs1, 0, rd, 7'b1100111);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic respond();
    if (dmem_req_o) begin
      if (dw == 0) begin
        d_a0 = dmem_addr_o; d_w0 = dmem_wdata_o; d_we0 = dmem_we_o;
      end else if (dmem_addr_o !== d_a0 || dmem_wdata_o !== d_w0 ||
                   dmem_we_o !== d_we0) begin
        d_unst = 1'b1;
      end
    end
    imem_ack_i   = spur_i || (imem_req_o && iw >= ilat);
    imem_rdata_i = imem[imem_addr_o[9:2]];
    if (imem_req_o && !imem_ack_i) iw++;
    else iw = 0;
    dmem_ack_i   = spur_d || (dmem_req_o && dw >= dlat);
    dmem_rdata_i = dmem[dmem_addr_o[9:2]];
    if (dmem_req_o && dmem_ack_i && dmem_we_o) begin
      dmem[dmem_addr_o[9:2]] = dmem_wdata_o;
      st_addr = dmem_addr_o;
      st_data = dmem_wdata_o;
    end
    if (dmem_req_o && !dmem_ack_i) dw++;
    else dw = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    respond();
    repeat (3) step();
    rst = 1'b0;
    #1;
    respond();
  endtask

  task automatic run_halt(input int maxc);
    int n;
    n = 0;
    while (!halted_o && n < maxc) begin
      step();
      n++;
    end
    chk("halt_reached", 32'(halted_o), 32'd1);
  endtask

  task automatic clear_mem();
    foreach (imem[i]) imem[i] = NOP;
    foreach (dmem[i]) dmem[i] = 32'hDEAD_BEEF;
    st_addr = 32'hFFFF_FFFF;
    st_data = 32'hDEAD_BEEF;
    d_unst  = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] p0, p1, p2;
    logic [31:0] exp_x2;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t vt [16];

  initial begin
    n_chk = 0; n_fail = 0;
    ilat = 0; dlat = 0; iw = 0; dw = 0;
    spur_i = 0; spur_d = 0;
    imem_ack_i = 0; dmem_ack_i = 0;
    imem_rdata_i = 0; dmem_rdata_i = 0;

    vt[0]  = '{"addi_chain", addi(1,0,5), addi(2,1,7), NOP,
               32'd12, 32'd5};
    vt[1]  = '{"sub", addi(1,0,3), rr(32,0,2,0,1), NOP,
               32'hFFFF_FFFD, 32'd5};
    vt[2]  = '{"lui_xori", u_t(1,32'h12345,7'b0110111),
               addi(1,1,32'h678), opi(4,2,1,-1),
               32'hEDCB_A987, 32'd5};
    vt[3]  = '{"srai", addi(1,0,-8), opi(5,2,1,32'h401), NOP,
               32'hFFFF_FFFC, 32'd5};
    vt[4]  = '{"srli", addi(1,0,-8), opi(5,2,1,28), NOP,
               32'h0000_000F, 32'd5};
    vt[5]  = '{"slt", addi(1,0,-1), addi(3,0,1), rr(0,2,2,1,3),
               32'd1, 32'd5};
    vt[6]  = '{"sltu", addi(1,0,-1), addi(3,0,1), rr(0,3,2,1,3),
               32'd0, 32'd5};
    vt[7]  = '{"auipc", NOP, NOP, u_t(2,1,7'b0010111),
               32'h0000_1108, 32'd5};
    vt[8]  = '{"x0_write", addi(0,0,7), rr(0,0,2,0,0), NOP,
               32'd0, 32'd5};
    vt[9]  = '{"andi", addi(1,0,32'hF0), opi(7,2,1,32'h3C), NOP,
               32'h30, 32'd5};
    vt[10] = '{"slli_ori", addi(1,0,1), opi(1,2,1,31), opi(6,2,2,15),
               32'h8000_000F, 32'd5};
    vt[11] = '{"beq_taken", addi(2,0,1), br(0,0,0,8), addi(2,0,99),
               32'd1, 32'd4};
    vt[12] = '{"bne_not", addi(2,0,1), br(1,0,0,8), addi(2,0,99),
               32'd99, 32'd5};
    vt[13] = '{"blt_taken", addi(2,0,-1), br(4,2,0,8), addi(2,0,99),
               32'hFFFF_FFFF, 32'd4};
    vt[14] = '{"bgeu_not", addi(2,0,-1), br(7,0,2,8), addi(2,0,99),
               32'd99, 32'd5};
    vt[15] = '{"jal_link", jal(2,8), addi(2,0,99), NOP,
               32'h0000_0104, 32'd4};

    // reset vector, req gating and first retirements
    clear_mem();
    imem[64] = addi(1,0,5); imem[65] = addi(2,1,7);
    imem[66] = sw(2,0,0);   imem[67] = jalr(0,0,2);
    rst = 1'b1;
    respond();
    step();
    chk("rst_ireq", 32'(imem_req_o), 32'd0);
    chk("rst_dreq", 32'(dmem_req_o), 32'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("first_ireq", 32'(imem_req_o), 32'd1);
    chk("first_iaddr", imem_addr_o, 32'h100);
    chk("rst_instret", instret_o, 32'd0);
    chk("rst_halted", 32'(halted_o), 32'd0);
    chk("rst_buserr", 32'(bus_err_o), 32'd0);
    respond();
    repeat (4) step();
    chk("instret_4cyc", instret_o, 32'd2);
    run_halt(50);
    chk("x2_sum", st_data, 32'd12);

    // table of short programs ending in store of x2 and a trap
    for (int k = 0; k < 16; k++) begin
      clear_mem();
      imem[64] = vt[k].p0; imem[65] = vt[k].p1; imem[66] = vt[k].p2;
      imem[67] = sw(2,0,0); imem[68] = jalr(0,0,2);
      do_reset();
      run_halt(100);
      chk({vt[k].name, "_x2"}, st_data, vt[k].exp_x2);
      chk({vt[k].name, "_ret"}, instret_o, vt[k].exp_ret);
    end
    chk("misalign_err", 32'(bus_err_o), 32'd1);

    // branch target fetch addresses
    clear_mem();
    imem[64] = br(0,0,0,8);
    do_reset();
    step(); step();
    chk("beq_fetch", imem_addr_o, 32'h108);
    imem[64] = br(1,0,0,8);
    do_reset();
    step(); step();
    chk("bne_fetch", imem_addr_o, 32'h104);

    // store then load with three wait states each
    clear_mem();
    dlat = 3;
    imem[64] = addi(2,0,12); imem[65] = sw(2,0,4);
    imem[66] = lw(3,0,4);    imem[67] = sw(3,0,8);
    imem[68] = jalr(0,0,2);
    do_reset();
    repeat (7) step();
    chk("sw_wait_ret", instret_o, 32'd1);
    chk("sw_dreq", 32'(dmem_req_o), 32'd1);
    chk("sw_we", 32'(dmem_we_o), 32'd1);
    chk("sw_addr", dmem_addr_o, 32'd4);
    chk("sw_wdata", dmem_wdata_o, 32'd12);
    chk("sw_size", 32'(dmem_size_o), 32'd2);
    step();
    chk("sw_ack_ret", instret_o, 32'd2);
    chk("ack_at_limit", 32'(bus_err_o), 32'd0);
    run_halt(100);
    chk("mem_stable", 32'(d_unst), 32'd0);
    chk("lw_st_addr", st_addr, 32'd8);
    chk("lw_x3", st_data, 32'd12);
    chk("mem_ret", instret_o, 32'd5);
    dlat = 0;

    // fetch timeout and frozen HALT
    clear_mem();
    ilat = 1000;
    do_reset();
    chk("to_req0", 32'(imem_req_o), 32'd1);
    repeat (3) step();
    chk("to_req3", 32'(imem_req_o), 32'd1);
    step();
    chk("to_req_drop", 32'(imem_req_o), 32'd0);
    chk("to_err", 32'(bus_err_o), 32'd1);
    chk("to_halt", 32'(halted_o), 32'd1);
    chk("to_pc", imem_addr_o, 32'h100);
    spur_i = 1'b1;
    spur_d = 1'b1;
    respond();
    repeat (5) step();
    chk("halt_frozen", 32'(halted_o), 32'd1);
    chk("halt_ret", instret_o, 32'd0);
    chk("halt_pc", imem_addr_o, 32'h100);
    spur_i = 1'b0;
    spur_d = 1'b0;
    ilat = 0;
    do_reset();
    chk("rst_clr_halt", 32'(halted_o), 32'd0);
    chk("rst_clr_err", 32'(bus_err_o), 32'd0);

    // jalr with rd == rs1
    clear_mem();
    imem[64] = addi(1,0,32'h140);
    imem[68] = jalr(1,1,0);
    imem[80] = sw(1,0,0);
    imem[81] = jalr(0,0,2);
    do_reset();
    repeat (10) step();
    chk("jalr_fetch", imem_addr_o, 32'h140);
    run_halt(50);
    chk("jalr_link", st_data, 32'h114);

    // reset during a data wait: no load writeback
    clear_mem();
    dmem[0] = 32'h55;
    dlat = 1000;
    imem[64] = addi(3,0,7);
    imem[65] = lw(3,0,0);
    do_reset();
    repeat (6) step();
    chk("mid_dreq", 32'(dmem_req_o), 32'd1);
    rst = 1'b1;
    spur_d = 1'b1;
    #1;
    chk("mid_rst_drop", 32'(dmem_req_o), 32'd0);
    respond();
    step(); step();
    imem[64] = sw(3,0,4);
    imem[65] = jalr(0,0,2);
    rst = 1'b0;
    spur_d = 1'b0;
    dlat = 0;
    #1;
    chk("mid_restart", imem_addr_o, 32'h100);
    respond();
    run_halt(50);
    chk("mid_no_wb", st_data, 32'd7);
    chk("mid_ret", instret_o, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
